// File: rtl/spi_pkg.sv
// spi_pkg: FSM state encoding, SPI mode constants and the length-field width helper
package spi_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SETUP, SHIFT, HOLD, GAP} state_t;
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;
  function automatic int len_w(input int data_len);
    return $clog2(data_len);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; ports clk/rst, wr_en/wr_data/full, rd_en/rd_data (registered on pop)/empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en && !full) wp <= wp + PW'(1);
      if (rd_en && !empty) begin
        rd_data <= mem[rp[AW-1:0]];
        rp <= rp + PW'(1);
      end
    end
  always_ff @(posedge clk)
    if (wr_en && !full) mem[wp[AW-1:0]] <= wr_data;
endmodule

// File: rtl/spi_tx_cfg.sv
// spi_tx_cfg: FIFO-fed SPI transmitter with per-frame length and latched CPOL/CPHA/bit-order/divider; bus outputs sclk_o/cs_n_o/sdo_o, status busy_o/done_o/tx_rdy_o
module spi_tx_cfg
  import spi_pkg::*;
#(
  parameter int DLY      = 1,
  parameter int DATA_LEN = 32,
  parameter int LEN_W    = len_w(DATA_LEN),
  parameter int DEPTH    = 16,
  parameter int DIV_W    = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cpol_i,
  input  logic                      cpha_i,
  input  logic                      lsb_first_i,
  input  logic [DIV_W-1:0]          div_i,
  input  logic [DATA_LEN+LEN_W-1:0] tx_data_i,
  input  logic                      tx_vld_i,
  output logic                      tx_rdy_o,
  output logic                      sclk_o,
  output logic                      cs_n_o,
  output logic                      sdo_o,
  output logic                      busy_o,
  output logic                      done_o
);
  localparam int EW = LEN_W + 2;
  if (DATA_LEN < 2 || DATA_LEN > 64 || DLY < 0) begin : g_bad_param
    $error("spi_tx_cfg: parameter out of range");
  end
  state_t state, state_nx;
  logic full, empty, pop;
  logic [DATA_LEN+LEN_W-1:0] rd_data;
  logic [DATA_LEN-1:0] sh, sh_nx;
  logic [LEN_W-1:0] len;
  logic [1:0] mode_l;
  logic lsb_l;
  logic [DIV_W-1:0] div_l, cnt;
  logic [EW-1:0] edges;
  logic tick, last, lead, ph1, bit_out, bit_nx, upd;
  logic sclk_nx, cs_n_nx, sdo_nx, done_nx;
  sync_fifo #(.WIDTH(DATA_LEN + LEN_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk_i), .rst(rst_i), .wr_en(tx_vld_i), .wr_data(tx_data_i), .full(full),
    .rd_en(pop), .rd_data(rd_data), .empty(empty)
  );
  assign tx_rdy_o = !full;
  assign busy_o = state != IDLE;
  assign pop = state == IDLE && !empty;
  assign tick = cnt == div_l;
  assign ph1 = mode_l inside {MODE1, MODE3};
  assign lead = !edges[0];
  // edges are numbered from 0, so the final trailing edge is 2n+1
  assign last = edges == EW'({len, 1'b1});
  assign bit_out = lsb_l ? sh[0] : sh[DATA_LEN-1];
  assign bit_nx = lsb_l ? sh[1] : sh[DATA_LEN-2];
  assign sh_nx = lsb_l ? sh >> 1 : sh << 1;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = empty ? IDLE : LOAD;
      LOAD:    state_nx = SETUP;
      SETUP:   state_nx = tick ? SHIFT : SETUP;
      SHIFT:   state_nx = tick && last ? HOLD : SHIFT;
      HOLD:    state_nx = tick ? GAP : HOLD;
      GAP:     state_nx = tick ? IDLE : GAP;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    upd = state == SHIFT && tick && (ph1 ? lead : !lead && !last);
    sclk_nx = state inside {IDLE, LOAD} ? cpol_i : state == SHIFT && tick ? !sclk_o : sclk_o;
    cs_n_nx = !(state inside {SETUP, SHIFT} || (state == HOLD && !tick));
    sdo_nx = state == SETUP && mode_l inside {MODE0, MODE2} ? bit_out : upd ? (ph1 ? bit_out : bit_nx) : sdo_o;
    done_nx = state == GAP && tick;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      sclk_o <= 1'b0;
      cs_n_o <= 1'b1;
      sdo_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state <= state_nx;
      sclk_o <= sclk_nx;
      cs_n_o <= cs_n_nx;
      sdo_o <= sdo_nx;
      done_o <= done_nx;
    end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cnt <= '0;
      edges <= '0;
      sh <= '0;
      len <= '0;
      mode_l <= MODE0;
      lsb_l <= 1'b0;
      div_l <= '0;
    end else begin
      cnt <= state inside {IDLE, LOAD} || tick ? '0 : cnt + DIV_W'(1);
      edges <= state == SHIFT ? edges + EW'(tick) : '0;
      if (state == LOAD) begin
        len <= rd_data[DATA_LEN +: LEN_W];
        // MSB-first frames are left-aligned so bit n sits at the top of the shifter
        sh <= lsb_first_i ? rd_data[DATA_LEN-1:0]
                          : rd_data[DATA_LEN-1:0] << (DATA_LEN - 1 - int'(rd_data[DATA_LEN +: LEN_W]));
        mode_l <= {cpol_i, cpha_i};
        lsb_l <= lsb_first_i;
        div_l <= div_i;
      end else if (upd) sh <= sh_nx;
    end
endmodule

// File: doc/spi_tx_cfg.md
SPI_TX_CFG -- requirements
Module: spi_tx_cfg

Interface
REQ-001 SHALL have parameter DLY, default 1, register-assignment delay for simulation.
REQ-002 SHALL have parameter DATA_LEN, default 32, maximum bits per frame (range 2..64).
REQ-003 SHALL have parameter LEN_W, default $clog2(DATA_LEN), width of the per-frame length field.
REQ-004 SHALL have parameter DEPTH, default 16, number of TX FIFO entries (power of 2).
REQ-005 SHALL have parameter DIV_W, default 8, width of the SCLK divider.
REQ-006 SHALL have port clk_i, input, 1, the single clock; one clock domain, asynchronous reset, active-high.
REQ-007 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port cpol_i, input, 1, idle SCLK level.
REQ-009 SHALL have port cpha_i, input, 1, 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-010 SHALL have port lsb_first_i, input, 1, bit order.
REQ-011 SHALL have port div_i, input, DIV_W, SCLK half-period of div_i+1 clk_i cycles.
REQ-012 SHALL have port tx_data_i, input, DATA_LEN+LEN_W; [DATA_LEN-1:0] carries right-aligned data and the upper LEN_W bits carry n, frame length n+1 bits.
REQ-013 SHALL have port tx_vld_i, input, 1, write strobe.
REQ-014 SHALL have port tx_rdy_o, output, 1, FIFO not full.
REQ-015 SHALL have ports sclk_o / cs_n_o / sdo_o, output, 1 each, SPI bus; all registered.
REQ-016 SHALL have port busy_o, output, 1, high when the FSM is not IDLE.
REQ-017 SHALL have port done_o, output, 1, one-cycle pulse at frame end.

Function
REQ-018 SHALL write a FIFO entry when tx_vld_i && tx_rdy_o; tx_vld_i while full is dropped with no state change.
REQ-019 SHALL run FSM states IDLE, LOAD, SETUP, SHIFT, HOLD, GAP.
REQ-020 SHALL pop in IDLE when FIFO not empty, then enter LOAD the next cycle.
REQ-021 SHALL in LOAD latch the shift register, length, cpol_i, cpha_i, lsb_first_i and div_i; config changes after LOAD take no effect until the next frame.
REQ-022 SHALL in SETUP drive cs_n_o low and, if CPHA=0, drive the first bit on sdo_o; SETUP lasts one half-period.
REQ-023 SHALL in SHIFT toggle sclk_o every half-period for 2*(n+1) edges, starting from latched CPOL.
REQ-024 SHALL with CPHA=0 update sdo_o on each trailing edge except the last; with CPHA=1 update sdo_o on each leading edge.
REQ-025 SHALL with MSB-first send bit n first, down to bit 0; with LSB-first send bit 0 up to bit n; bits above n are ignored.
REQ-026 SHALL after the last edge enter HOLD (one half-period, cs_n_o low), then deassert cs_n_o and enter GAP (one half-period).
REQ-027 SHALL pulse done_o on the GAP->IDLE transition; back-to-back frames SHALL keep cs_n_o high for at least one half-period plus 2 clk_i cycles.
REQ-028 SHALL in IDLE register sclk_o <= cpol_i every cycle and hold sdo_o at its last value.
REQ-029 SHALL treat n=0 as a legal 1-bit frame; div_i=0 yields SCLK = clk_i/2.
REQ-030 SHALL let FIFO write and pop occur in the same cycle; with the FIFO empty the FSM stays in IDLE with cs_n_o high.

Reset
REQ-031 SHALL on rst_i immediately set sclk_o=0, cs_n_o=1, sdo_o=0, busy_o=0, done_o=0, FSM=IDLE, counters=0, FIFO empty, tx_rdy_o=1.
REQ-032 SHALL abort a frame on reset mid-frame with cs_n_o high asynchronously; no done_o is issued.

Structure
REQ-033 SHALL place FSM state encoding, SPI mode constants and the length-field width function in shared package spi_pkg.
REQ-034 SHALL instantiate sync_fifo (WIDTH=DATA_LEN+LEN_W, DEPTH) as the single sub-module; the half-period divider, edge counter and shifter are local.

Verification
REQ-035 SHALL verify Mode 0, div=1, n=7, data 0xA5, MSB-first -> 8 rising edges sample 1,0,1,0,0,1,0,1; SCLK period 4 clk_i; done_o once.
REQ-036 SHALL verify Mode 3, div=0, n=15, 0x1234, LSB-first -> sdo changes on falling edges; sampled bits equal 0x1234 reversed order; idle sclk_o=1.
REQ-037 SHALL verify 17 writes with DEPTH=16 while the FSM is stalled (no pop) -> tx_rdy_o=0 after the 16th write, 17th dropped, exactly 16 frames emitted.
REQ-038 SHALL verify back-to-back frames n=0, data 1 and 0 -> two 1-bit frames; cs_n_o high between them for >= half-period+2 cycles.
REQ-039 SHALL verify rst_i asserted mid-SHIFT of a 32-bit frame -> cs_n_o=1, busy_o=0 in the same cycle, FIFO empty, no done_o.
REQ-040 SHALL verify cpha_i toggled during a frame -> the current frame is unchanged and the next frame uses the new mode.
